// File: rtl/mestpro_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode legality check
// for the MestPro accumulator core and its program sequencer.
package mestpro_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LOAD = 8'h01;
   localparam logic [7:0] OP_ADD  = 8'h02;
   localparam logic [7:0] OP_SUB  = 8'h03;
   localparam logic [7:0] OP_AND  = 8'h04;
   localparam logic [7:0] OP_OR   = 8'h05;
   localparam logic [7:0] OP_XOR  = 8'h06;
   localparam logic [7:0] OP_OUT  = 8'h07;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFinish} state_e;

   function automatic logic is_legal(input logic [7:0] op);
      return (op <= OP_OUT) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/mestpro_prog_buf.sv
// Program buffer: DEPTH x 16-bit words {opcode, operand}, appended at count,
// synchronous write, asynchronous read. Only count is reset.
module mestpro_prog_buf #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              clear_i,
   input  logic              wr_en_i,
   input  logic [15:0]       wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [15:0]       rd_data_o,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o
);

   localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

   logic [15:0]       mem_q [DEPTH];
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] wr_ptr;
   logic              do_wr;

   // Words are only ever appended, so the write pointer is the low bits of count.
   assign wr_ptr  = count_q[ADDR_W-1:0];
   assign full_o  = (count_q == DepthCnt);
   assign count_o = count_q;
   assign do_wr   = wr_en_i && !full_o && !clear_i;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (do_wr) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_wr) begin
         mem_q[wr_ptr] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mestpro_sequencer.sv
// Program sequencer for the MestPro core: loads (opcode, operand) words from the
// host, issues one per cycle on START and captures the core output after each OUT.
module mestpro_sequencer
   import mestpro_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLEAR,
   input  logic       LOAD_VALID,
   input  logic [7:0] LOAD_OPCODE,
   input  logic [7:0] LOAD_OPERAND,
   output logic       LOAD_READY,
   input  logic       START,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERROR,
   output logic [7:0] INSTRUCTION,
   output logic [7:0] IN_DATA,
   input  logic [7:0] CORE_OUT,
   output logic [7:0] RESULT,
   output logic       RESULT_VALID
);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   pc_q, pc_d, fetch_addr, count;
   logic [7:0]        instr_q, instr_d, data_q, data_d, result_q, result_d;
   logic [7:0]        fetch_op, fetch_arg;
   logic [15:0]       rd_data;
   logic [1:0]        out_sr_q, out_sr_d;
   logic              error_q, error_d, drain_q, drain_d;
   logic              fetch, full, buf_clear, buf_wr;

   mestpro_prog_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_buf (
      .CLK       (CLK),
      .RESET     (RESET),
      .clear_i   (buf_clear),
      .wr_en_i   (buf_wr),
      .wr_data_i ({LOAD_OPCODE, LOAD_OPERAND}),
      .rd_addr_i (fetch_addr[ADDR_W-1:0]),
      .rd_data_o (rd_data),
      .count_o   (count),
      .full_o    (full)
   );

   // The word fetched on the START edge is entry 0, so it appears on the bus at t+1.
   assign fetch_addr = (state_q == StRun) ? pc_q : '0;
   assign fetch_op   = rd_data[15:8];
   assign fetch_arg  = rd_data[7:0];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= StIdle;
         pc_q     <= '0;
         drain_q  <= 1'b0;
         instr_q  <= '0;
         data_q   <= '0;
         error_q  <= 1'b0;
         out_sr_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         drain_q  <= drain_d;
         instr_q  <= instr_d;
         data_q   <= data_d;
         error_q  <= error_d;
         out_sr_q <= out_sr_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drain_d = drain_q;
      instr_d = '0;
      data_d  = '0;
      error_d = error_q;
      fetch   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (START) begin
               error_d = 1'b0;
               pc_d    = '0;
               if (count == '0) state_d = StFinish;
               else             fetch   = 1'b1;
            end
         end
         StRun: begin
            if (pc_q == count) state_d = StDrain;
            else               fetch   = 1'b1;
         end
         StDrain: begin
            drain_d = !drain_q;
            if (drain_q) state_d = StFinish;
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      if (fetch) begin
         if (fetch_op == OP_HALT) begin
            state_d = StDrain;
         end else if (!is_legal(fetch_op)) begin
            state_d = StDrain;
            error_d = 1'b1;
         end else begin
            state_d = StRun;
            instr_d = fetch_op;
            data_d  = (fetch_op == OP_LOAD) ? fetch_arg : 8'h00;
            pc_d    = fetch_addr + 1'b1;
         end
      end
      // Core updates OUT_DATA at the end of the issue cycle; sample one cycle later.
      out_sr_d = {out_sr_q[0], instr_q == OP_OUT};
      result_d = out_sr_q[0] ? CORE_OUT : result_q;
   end

   always_comb begin
      BUSY       = (state_q == StRun) || (state_q == StDrain);
      DONE       = (state_q == StFinish);
      LOAD_READY = (state_q == StIdle) && !full;
      buf_clear  = (state_q == StIdle) && CLEAR;
      buf_wr     = LOAD_VALID && LOAD_READY && !CLEAR;
   end

   assign INSTRUCTION  = instr_q;
   assign IN_DATA      = data_q;
   assign ERROR        = error_q;
   assign RESULT       = result_q;
   assign RESULT_VALID = out_sr_q[1];

endmodule

// File: tb/tb_mestpro_sequencer.sv
// Directed bench for mestpro_sequencer with a behavioural accumulator core and a
// scoreboard of expected RESULT values.
module tb_mestpro_sequencer;

   localparam int unsigned DEPTH = 16;

   logic       CLK = 1'b0;
   logic       RESET, CLEAR, LOAD_VALID, START;
   logic [7:0] LOAD_OPCODE, LOAD_OPERAND;
   logic       LOAD_READY, BUSY, DONE, ERROR, RESULT_VALID;
   logic [7:0] INSTRUCTION, IN_DATA, CORE_OUT, RESULT;

   int         errors = 0;
   int         checks = 0;
   bit [7:0]   sb[$];
   logic       busy_ok, err_at_t1, core_clr;
   int         lat;

   mestpro_sequencer #(.DEPTH(DEPTH)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .CLEAR        (CLEAR),
      .LOAD_VALID   (LOAD_VALID),
      .LOAD_OPCODE  (LOAD_OPCODE),
      .LOAD_OPERAND (LOAD_OPERAND),
      .LOAD_READY   (LOAD_READY),
      .START        (START),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .ERROR        (ERROR),
      .INSTRUCTION  (INSTRUCTION),
      .IN_DATA      (IN_DATA),
      .CORE_OUT     (CORE_OUT),
      .RESULT       (RESULT),
      .RESULT_VALID (RESULT_VALID)
   );

   always #5 CLK = ~CLK;

   // Behavioural accumulator core: A register, accumulator, registered OUT_DATA.
   logic [7:0] acc, areg;
   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         acc <= 8'h00; areg <= 8'h00; CORE_OUT <= 8'h00;
      end else if (core_clr) begin
         acc <= 8'h00; areg <= 8'h00; CORE_OUT <= 8'h00;
      end else begin
         case (INSTRUCTION)
            8'd1: areg <= IN_DATA;
            8'd2: acc <= acc + areg;
            8'd3: acc <= acc - areg;
            8'd4: acc <= acc & areg;
            8'd5: acc <= acc | areg;
            8'd6: acc <= acc ^ areg;
            8'd7: CORE_OUT <= acc;
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then drain the scoreboard on any RESULT strobe.
   task automatic tick();
      bit [7:0] e;
      @(posedge CLK);
      #1;
      if (RESULT_VALID === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_result_valid", RESULT_VALID, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", RESULT, e);
         end
      end
   endtask

   task automatic load(input logic [7:0] op, input logic [7:0] arg);
      int n = 0;
      LOAD_VALID = 1'b1; LOAD_OPCODE = op; LOAD_OPERAND = arg;
      while (LOAD_READY !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n == 50) chk("load_ready_timeout", LOAD_READY, 32'd1);
      tick();
      LOAD_VALID = 1'b0;
   endtask

   task automatic clear_buf();
      CLEAR = 1'b1;
      tick();
      CLEAR = 1'b0;
   endtask

   task automatic core_reset();
      core_clr = 1'b1;
      tick();
      core_clr = 1'b0;
   endtask

   // Pulse START and wait for DONE; lat counts cycles from the START cycle.
   task automatic run(input string tag, input int exp_lat);
      START = 1'b1;
      busy_ok = 1'b1;
      tick();
      START = 1'b0;
      err_at_t1 = ERROR;
      lat = 1;
      while (DONE !== 1'b1 && lat < 100) begin
         if (BUSY !== 1'b1) busy_ok = 1'b0;
         tick();
         lat++;
      end
      chk({tag, "_done"}, DONE, 32'd1);
      if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
      tick();
      chk({tag, "_done_pulse"}, DONE, 32'd0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_instruction"}, INSTRUCTION, 32'd0);
      chk({tag, "_in_data"}, IN_DATA, 32'd0);
      chk({tag, "_result"}, RESULT, 32'd0);
      chk({tag, "_result_valid"}, RESULT_VALID, 32'd0);
      chk({tag, "_busy"}, BUSY, 32'd0);
      chk({tag, "_done"}, DONE, 32'd0);
      chk({tag, "_error"}, ERROR, 32'd0);
      chk({tag, "_load_ready"}, LOAD_READY, 32'd1);
   endtask

   initial begin
      RESET = 1'b0; CLEAR = 1'b0; LOAD_VALID = 1'b0; START = 1'b0;
      LOAD_OPCODE = 8'h00; LOAD_OPERAND = 8'h00; core_clr = 1'b0;
      busy_ok = 1'b1; err_at_t1 = 1'b0; lat = 0;
      @(posedge CLK);
      #1;
      chk_reset_values("por");
      @(posedge CLK);
      #1;
      RESET = 1'b1;

      // A = 5, ACC += 5, A = 3, ACC -= 3, OUT -> 2
      load(8'd1, 8'h05); load(8'd2, 8'h00); load(8'd1, 8'h03);
      load(8'd3, 8'h00); load(8'd7, 8'h00);
      core_reset();
      sb.push_back(8'h02);
      run("t1", 8);
      chk("t1_results_left", sb.size(), 32'd0);
      chk("t1_error", ERROR, 32'd0);

      // ACC |= F0, ACC ^= 3C -> CC, twice
      clear_buf();
      load(8'd1, 8'hF0); load(8'd5, 8'h00); load(8'd1, 8'h3C);
      load(8'd6, 8'h00); load(8'd7, 8'h00); load(8'd7, 8'h00);
      core_reset();
      sb.push_back(8'hCC); sb.push_back(8'hCC);
      run("t2", 9);
      chk("t2_busy_throughout", busy_ok, 32'd1);
      chk("t2_results_left", sb.size(), 32'd0);

      // HALT stops the run before the OUT is issued
      clear_buf();
      load(8'd1, 8'h01); load(8'd2, 8'h00); load(8'hFF, 8'h00); load(8'd7, 8'h00);
      core_reset();
      run("t3", 0);
      chk("t3_error", ERROR, 32'd0);

      // Illegal opcode sets ERROR; a new START clears it before the replay re-hits it
      clear_buf();
      load(8'd1, 8'h01); load(8'h09, 8'h00); load(8'd7, 8'h00);
      run("t4", 0);
      chk("t4_error_set", ERROR, 32'd1);
      run("t4b", 0);
      chk("t4b_error_cleared_by_start", err_at_t1, 32'd0);
      chk("t4b_error_set_again", ERROR, 32'd1);

      // Fill the buffer, offer one more, then clear and run empty
      clear_buf();
      for (int i = 0; i < DEPTH; i++) load(8'd0, 8'(i));
      chk("t5_full_ready", LOAD_READY, 32'd0);
      run("t5_full_run", DEPTH + 3);
      LOAD_VALID = 1'b1; LOAD_OPCODE = 8'd7; LOAD_OPERAND = 8'h00;
      tick(); tick(); tick();
      chk("t5_offer_pending", LOAD_READY, 32'd0);
      LOAD_VALID = 1'b0;
      clear_buf();
      chk("t5_ready_after_clear", LOAD_READY, 32'd1);
      run("t5_empty", 1);

      // Reset in the middle of a 10-word run
      clear_buf();
      load(8'd1, 8'h01);
      for (int i = 0; i < 4; i++) begin
         load(8'd2, 8'h00);
         load(8'd7, 8'h00);
      end
      load(8'd0, 8'h00);
      core_reset();
      sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03); sb.push_back(8'h04);
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("t6_busy_before_reset", BUSY, 32'd1);
      #2;
      RESET = 1'b0;
      #1;
      chk_reset_values("t6_midrun");
      sb.delete();
      tick();
      RESET = 1'b1;
      load(8'd1, 8'h05); load(8'd2, 8'h00); load(8'd1, 8'h03);
      load(8'd3, 8'h00); load(8'd7, 8'h00);
      core_reset();
      sb.push_back(8'h02);
      run("t6_rerun", 8);
      chk("t6_results_left", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mestpro_sequencer.md
# mestpro_sequencer

Program sequencer that drives the MestPro accumulator core. A host loads a short program of (opcode, operand) pairs into an internal buffer, then pulses START. The block issues one instruction per cycle on INSTRUCTION/IN_DATA, captures the core's OUT_DATA after every output instruction, and reports each value on a RESULT/RESULT_VALID strobe. It is the initiator side of the core's instruction interface and sits between the host bus and the core.

## Interface
- DEPTH, 16: program buffer entries; power of two, 2..256
- ADDR_W, $clog2(DEPTH): buffer index width
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-low
- CLEAR  in  1  empties program buffer; honoured only in IDLE
- LOAD_VALID  in  1  host offers a program word
- LOAD_OPCODE  in  8  opcode of offered word
- LOAD_OPERAND  in  8  operand; meaningful only for opcode 1
- LOAD_READY  out  1  buffer accepts a word (IDLE and not full)
- START  in  1  begin execution; honoured only in IDLE
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  one-cycle pulse when execution ends
- ERROR  out  1  sticky; set on illegal opcode, cleared by START or reset
- INSTRUCTION  out  8  to core INSTRUCTION
- IN_DATA  out  8  to core IN_DATA
- CORE_OUT  in  8  from core OUT_DATA
- RESULT  out  8  captured core output
- RESULT_VALID  out  1  one-cycle strobe, RESULT is valid

## Operation
- Opcodes: 0 NOP, 1 LOAD A, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 OUT, 8'hFF HALT (sequencer-local, never issued). 8..8'hFE illegal.
- Load: a word is written at wr_ptr when LOAD_VALID && LOAD_READY; count increments. LOAD_READY = IDLE && count < DEPTH. Offers while full or not IDLE are not written; the host holds LOAD_VALID until LOAD_READY is seen.
- CLEAR in IDLE sets count=0. CLEAR takes priority over a same-cycle load.
- States: IDLE, RUN, DRAIN, FINISH.
  - IDLE -> RUN on START with count>0; pc=0, ERROR cleared.
  - IDLE -> FINISH on START with count=0.
  - RUN: each cycle reads entry pc and registers INSTRUCTION=opcode and IN_DATA=operand (0 unless opcode 1). pc increments.
  - RUN -> DRAIN after issuing entry count-1, or on reading HALT (not issued), or on reading an illegal opcode (not issued, ERROR set).
  - DRAIN: 2 cycles so that the last OUT result is captured. -> FINISH.
  - FINISH: DONE=1 for one cycle. -> IDLE.
- START and CLEAR outside IDLE are ignored. LOAD_VALID outside IDLE is stalled.
- The program is retained after a run. A new START replays it; further loads append.
- Outside RUN, INSTRUCTION=0 and IN_DATA=0. The core treats 0 as a no-op.
- Result capture: the 7-flag is tracked in a 2-stage shift register. RESULT<=CORE_OUT and RESULT_VALID=1 two cycles after the issue cycle of each 7. Back-to-back 7s give back-to-back strobes.
- The core's ACC/A are not reset by this block. Both blocks share RESET.

## Timing
- Reset values: INSTRUCTION=0, IN_DATA=0, RESULT=0, RESULT_VALID=0, BUSY=0, DONE=0, ERROR=0, LOAD_READY=1. State IDLE, count=0, pc=0, shift register 0.
- Cycle t: START is sampled. t+1: entry 0 is on INSTRUCTION. t+k: entry k-1 is on INSTRUCTION.
- A 7 driven in cycle c: the core updates OUT_DATA at the end of c. The sequencer samples CORE_OUT at the end of c+1. RESULT_VALID is high in cycle c+2.
- Normal end with N entries: DONE at t+N+3. With count=0: DONE at t+1.
- Reset mid-run aborts immediately to the reset values. Buffer contents are undefined, count=0.
- Throughput: 1 instruction/cycle, no stalls.

## Structure
- Package mestpro_pkg: the opcode localparams (OP_NOP..OP_OUT, OP_HALT), a state enum, and an is_legal() function. The core should adopt the same opcode constants.
- Sub-module mestpro_prog_buf: DEPTH x 16-bit buffer with synchronous write and asynchronous read, wr_ptr and count. It is resettable only through count.
- The top level holds the FSM, pc, the issue registers and the result-capture shift register.

## Test plan
- Load {1,0x05},{2},{1,0x03},{3},{7}, core reset, then START: exactly one RESULT_VALID with RESULT=0x02. DONE 8 cycles after START.
- Load {1,0xF0},{5},{1,0x3C},{6},{7},{7}: two consecutive strobes, both RESULT=0xCC. BUSY is high throughout the run.
- Load {1,0x01},{2},{0xFF},{7}: HALT stops the run, the 7 is never issued, no RESULT_VALID, DONE pulses, ERROR=0.
- Load {1,0x01},{0x09},{7}: ERROR=1 and DONE pulses with no result. The next START clears ERROR.
- Load DEPTH words: LOAD_READY drops, and the (DEPTH+1)th offer stays pending. CLEAR gives LOAD_READY=1 and count=0. START with an empty buffer gives DONE 1 cycle later.
- Assert RESET in the middle of a 10-word run: all outputs return to their reset values within the same cycle. A later START after reload runs correctly.
